// File: rtl/gate_pkg.sv
// Shared constants for the garage gate arbiter: state codes, gate directions,
// default capacity and a small sizing helper.
package gate_pkg;

   localparam int unsigned STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
   localparam logic [STATE_W-1:0] ST_OPEN_IN  = 3'd1;
   localparam logic [STATE_W-1:0] ST_OPEN_OUT = 3'd2;
   localparam logic [STATE_W-1:0] ST_CLOSE    = 3'd3;

   localparam logic DIR_IN  = 1'b1;
   localparam logic DIR_OUT = 1'b0;

   localparam int unsigned MAX_CARS_DEF = 50;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/req_latch.sv
// Rising-edge detector on a debounced request level feeding a sticky pending
// bit; the clear input wins over a coincident edge.
module req_latch (
   input  logic clk,
   input  logic reset,
   input  logic req,
   input  logic clr,
   output logic pending
);

   logic req_q;
   logic rise_c;

   assign rise_c = req & ~req_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req_q   <= 1'b0;
         pending <= 1'b0;
      end else begin
         req_q <= req;
         if (clr) begin
            pending <= 1'b0;
         end else if (rise_c) begin
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/gate_arbiter.sv
// Single-lane barrier controller: arbitrates entry/exit requests round-robin,
// sequences the gate and pulses the occupancy counter up or down.
module gate_arbiter
   import gate_pkg::*;
#(
   parameter int unsigned MAX_CARS     = MAX_CARS_DEF,
   parameter int unsigned PASS_TIMEOUT = 64,
   parameter int unsigned CLOSE_HOLD   = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                entry_req,
   input  logic                exit_req,
   input  logic                car_passed,
   input  logic [5:0]          count,
   output logic                gate_open,
   output logic                gate_dir,
   output logic                cnt_up,
   output logic                cnt_down,
   output logic                full,
   output logic                empty,
   output logic                reject,
   output logic                timeout,
   output logic [STATE_W-1:0]  state
);

   localparam int unsigned TIMER_W = $clog2(max_u(PASS_TIMEOUT, CLOSE_HOLD) + 1);
   localparam logic [TIMER_W-1:0] PASS_LAST = TIMER_W'(PASS_TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(CLOSE_HOLD - 1);

   logic               pend_in;
   logic               pend_out;
   logic               clr_in;
   logic               clr_out;
   logic [STATE_W-1:0] state_next;
   logic [TIMER_W-1:0] timer;
   logic [TIMER_W-1:0] timer_next;
   logic               last_served;
   logic               last_served_next;
   logic               rej_c;
   logic               passed_c;
   logic               expired_c;
   logic               gate_open_d;
   logic               gate_dir_d;
   logic               cnt_up_d;
   logic               cnt_down_d;
   logic               reject_d;
   logic               timeout_d;

   assign full  = (count >= 6'(MAX_CARS));
   assign empty = (count == 6'd0);

   req_latch u_entry_latch (
      .clk     (clk),
      .reset   (reset),
      .req     (entry_req),
      .clr     (clr_in),
      .pending (pend_in)
   );

   req_latch u_exit_latch (
      .clk     (clk),
      .reset   (reset),
      .req     (exit_req),
      .clr     (clr_out),
      .pending (pend_out)
   );

   // State, timer, round-robin pointer and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         timer       <= '0;
         last_served <= DIR_OUT;
         gate_open   <= 1'b0;
         gate_dir    <= 1'b0;
         cnt_up      <= 1'b0;
         cnt_down    <= 1'b0;
         reject      <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         state       <= state_next;
         timer       <= timer_next;
         last_served <= last_served_next;
         gate_open   <= gate_open_d;
         gate_dir    <= gate_dir_d;
         cnt_up      <= cnt_up_d;
         cnt_down    <= cnt_down_d;
         reject      <= reject_d;
         timeout     <= timeout_d;
      end
   end

   // Grant decision, pass/timeout detection and close hold.
   always_comb begin
      state_next       = state;
      clr_in           = 1'b0;
      clr_out          = 1'b0;
      last_served_next = last_served;
      rej_c            = 1'b0;
      passed_c         = 1'b0;
      expired_c        = 1'b0;
      case (state)
         ST_IDLE: begin
            // With both pending, the side not served last time wins.
            if (pend_in && (!pend_out || (last_served == DIR_OUT))) begin
               clr_in = 1'b1;
               if (full) begin
                  rej_c = 1'b1;
               end else begin
                  state_next       = ST_OPEN_IN;
                  last_served_next = DIR_IN;
               end
            end else if (pend_out) begin
               clr_out = 1'b1;
               if (empty) begin
                  rej_c = 1'b1;
               end else begin
                  state_next       = ST_OPEN_OUT;
                  last_served_next = DIR_OUT;
               end
            end
         end
         ST_OPEN_IN, ST_OPEN_OUT: begin
            if (car_passed) begin
               passed_c   = 1'b1;
               state_next = ST_CLOSE;
            end else if (timer == PASS_LAST) begin
               expired_c  = 1'b1;
               state_next = ST_CLOSE;
            end
         end
         ST_CLOSE: begin
            if (timer == HOLD_LAST) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      timer_next = ((state_next != state) || (state == ST_IDLE)) ? '0 : timer + TIMER_W'(1);
   end

   // Next values of the registered outputs.
   always_comb begin
      gate_open_d = 1'b0;
      gate_dir_d  = 1'b0;
      cnt_up_d    = 1'b0;
      cnt_down_d  = 1'b0;
      reject_d    = rej_c;
      timeout_d   = expired_c;
      if ((state_next == ST_OPEN_IN) || (state_next == ST_OPEN_OUT)) begin
         gate_open_d = 1'b1;
         gate_dir_d  = (state_next == ST_OPEN_IN) ? DIR_IN : DIR_OUT;
      end
      if (passed_c) begin
         cnt_up_d   = (state == ST_OPEN_IN);
         cnt_down_d = (state == ST_OPEN_OUT);
      end
   end

endmodule

// File: tb/tb_gate_arbiter.sv
// Directed bench for gate_arbiter: expected output snapshots are queued with
// each stimulus step and popped against the DUT after the step completes.
module tb_gate_arbiter;

   typedef struct packed {
      logic       gate_open;
      logic       gate_dir;
      logic       cnt_up;
      logic       cnt_down;
      logic       reject;
      logic       timeout;
      logic       full;
      logic       empty;
      logic [2:0] state;
   } obs_t;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_IN   = 3'd1;
   localparam logic [2:0] S_OUT  = 3'd2;
   localparam logic [2:0] S_CLS  = 3'd3;

   logic       clk = 1'b0;
   logic       reset;
   logic       entry_req;
   logic       exit_req;
   logic       car_passed;
   logic [5:0] count;
   logic       gate_open;
   logic       gate_dir;
   logic       cnt_up;
   logic       cnt_down;
   logic       full;
   logic       empty;
   logic       reject;
   logic       timeout;
   logic [2:0] state;

   int   checks   = 0;
   int   failures = 0;
   obs_t  exp_q[$];
   string tag_q[$];

   gate_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .entry_req  (entry_req),
      .exit_req   (exit_req),
      .car_passed (car_passed),
      .count      (count),
      .gate_open  (gate_open),
      .gate_dir   (gate_dir),
      .cnt_up     (cnt_up),
      .cnt_down   (cnt_down),
      .full       (full),
      .empty      (empty),
      .reject     (reject),
      .timeout    (timeout),
      .state      (state)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_q();
      obs_t       e;
      obs_t       got;
      string      t;
      logic [10:0] eb;
      logic [10:0] gb;
      while (exp_q.size() != 0) begin
         e   = exp_q.pop_front();
         t   = tag_q.pop_front();
         got = '{gate_open, gate_dir, cnt_up, cnt_down, reject, timeout, full, empty, state};
         eb  = e;
         gb  = got;
         checks++;
         assert (got === e) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b (open dir up dn rej to full empty state)", t, gb, eb);
         end
      end
   endtask

   // Queue the expected snapshot, advance n edges, then compare.
   task automatic ea(input int n, input string tag, input logic go, input logic dir,
                     input logic up, input logic dn, input logic rej, input logic to,
                     input logic [2:0] st);
      obs_t e;
      e.gate_open = go;
      e.gate_dir  = dir;
      e.cnt_up    = up;
      e.cnt_down  = dn;
      e.reject    = rej;
      e.timeout   = to;
      e.full      = (count >= 6'd50);
      e.empty     = (count == 6'd0);
      e.state     = st;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      step(n);
      check_q();
   endtask

   initial begin
      reset      = 1'b0;
      entry_req  = 1'b0;
      exit_req   = 1'b0;
      car_passed = 1'b0;
      count      = 6'd5;
      #2;
      ea(0, "reset_state", 0, 0, 0, 0, 0, 0, S_IDLE);
      step(1);
      reset = 1'b1;

      // Entry, normal pass
      entry_req = 1'b1;
      ea(1, "in_edge", 0, 0, 0, 0, 0, 0, S_IDLE);
      ea(1, "in_open", 1, 1, 0, 0, 0, 0, S_IN);
      entry_req = 1'b0;
      ea(3, "in_hold", 1, 1, 0, 0, 0, 0, S_IN);
      car_passed = 1'b1;
      ea(1, "in_pass", 0, 0, 1, 0, 0, 0, S_CLS);
      car_passed = 1'b0;
      ea(1, "in_up_once", 0, 0, 0, 0, 0, 0, S_CLS);
      ea(2, "in_close", 0, 0, 0, 0, 0, 0, S_CLS);
      ea(1, "in_idle", 0, 0, 0, 0, 0, 0, S_IDLE);

      // Full garage rejects entry, exit still served
      count     = 6'd50;
      entry_req = 1'b1;
      ea(1, "full_edge", 0, 0, 0, 0, 0, 0, S_IDLE);
      ea(1, "full_reject", 0, 0, 0, 0, 1, 0, S_IDLE);
      ea(1, "full_rej_once", 0, 0, 0, 0, 0, 0, S_IDLE);
      entry_req = 1'b0;
      exit_req  = 1'b1;
      ea(2, "out_open", 1, 0, 0, 0, 0, 0, S_OUT);
      exit_req   = 1'b0;
      car_passed = 1'b1;
      ea(1, "out_pass", 0, 0, 0, 1, 0, 0, S_CLS);
      car_passed = 1'b0;
      ea(4, "out_idle", 0, 0, 0, 0, 0, 0, S_IDLE);

      // Simultaneous requests after reset: entry first, exit after close
      reset = 1'b0;
      count = 6'd5;
      ea(0, "rst_pulse", 0, 0, 0, 0, 0, 0, S_IDLE);
      step(1);
      reset     = 1'b1;
      entry_req = 1'b1;
      exit_req  = 1'b1;
      ea(2, "both_in_first", 1, 1, 0, 0, 0, 0, S_IN);
      entry_req  = 1'b0;
      exit_req   = 1'b0;
      car_passed = 1'b1;
      ea(1, "both_in_pass", 0, 0, 1, 0, 0, 0, S_CLS);
      car_passed = 1'b0;
      ea(4, "both_close_idle", 0, 0, 0, 0, 0, 0, S_IDLE);
      ea(1, "both_out_next", 1, 0, 0, 0, 0, 0, S_OUT);
      car_passed = 1'b1;
      ea(1, "both_out_pass", 0, 0, 0, 1, 0, 0, S_CLS);
      car_passed = 1'b0;
      ea(4, "both_idle", 0, 0, 0, 0, 0, 0, S_IDLE);

      // Timeout with no car
      entry_req = 1'b1;
      ea(2, "to_open", 1, 1, 0, 0, 0, 0, S_IN);
      entry_req = 1'b0;
      ea(63, "to_last", 1, 1, 0, 0, 0, 0, S_IN);
      ea(1, "to_fire", 0, 0, 0, 0, 0, 1, S_CLS);
      ea(1, "to_once", 0, 0, 0, 0, 0, 0, S_CLS);
      ea(3, "to_idle", 0, 0, 0, 0, 0, 0, S_IDLE);

      // car_passed in the expiry cycle wins over timeout
      entry_req = 1'b1;
      ea(2, "race_open", 1, 1, 0, 0, 0, 0, S_IN);
      entry_req = 1'b0;
      ea(63, "race_last", 1, 1, 0, 0, 0, 0, S_IN);
      car_passed = 1'b1;
      ea(1, "race_pass", 0, 0, 1, 0, 0, 0, S_CLS);
      car_passed = 1'b0;
      ea(4, "race_idle", 0, 0, 0, 0, 0, 0, S_IDLE);

      // Empty garage rejects exit; stray sensor in IDLE ignored
      count    = 6'd0;
      exit_req = 1'b1;
      ea(2, "empty_reject", 0, 0, 0, 0, 1, 0, S_IDLE);
      exit_req = 1'b0;
      ea(1, "empty_rej_once", 0, 0, 0, 0, 0, 0, S_IDLE);
      car_passed = 1'b1;
      ea(1, "stray_sensor", 0, 0, 0, 0, 0, 0, S_IDLE);
      car_passed = 1'b0;
      ea(1, "stray_quiet", 0, 0, 0, 0, 0, 0, S_IDLE);

      // Async reset while open, with an exit request pending
      count     = 6'd5;
      entry_req = 1'b1;
      ea(2, "mid_open", 1, 1, 0, 0, 0, 0, S_IN);
      entry_req = 1'b0;
      exit_req  = 1'b1;
      ea(2, "mid_pend", 1, 1, 0, 0, 0, 0, S_IN);
      #3;
      reset      = 1'b0;
      car_passed = 1'b1;
      ea(0, "mid_rst", 0, 0, 0, 0, 0, 0, S_IDLE);
      exit_req = 1'b0;
      ea(1, "mid_in_rst", 0, 0, 0, 0, 0, 0, S_IDLE);
      reset      = 1'b1;
      car_passed = 1'b0;
      ea(1, "mid_rel", 0, 0, 0, 0, 0, 0, S_IDLE);
      ea(3, "mid_quiet", 0, 0, 0, 0, 0, 0, S_IDLE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gate_arbiter.md
Name: gate_arbiter

Overview:
Single-lane barrier controller for the garage. It arbitrates between entry and exit requests that share one physical gate and sequences the barrier open/close. It emits one-cycle up/down pulses to the occupancy counter and refuses entry when the garage is at capacity. The block sits between the debounced push-button/sensor inputs and the BCD occupancy counter, and reads that counter's value back.

Parameters:
MAX_CARS, 50, occupancy at which entry is refused (1..63)
PASS_TIMEOUT, 64, cycles the gate stays open waiting for car_passed before aborting
CLOSE_HOLD, 4, cycles spent in CLOSE before returning to IDLE; lets the counter settle

Ports:
clk  input  1  system clock (slow debounced clock domain)
reset  input  1  asynchronous, active-low reset
entry_req  input  1  debounced entry request level
exit_req  input  1  debounced exit request level
car_passed  input  1  lane sensor, one-cycle pulse when a car clears the gate
count  input  6  current occupancy from the counter
gate_open  output  1  barrier open command
gate_dir  output  1  1 = serving entry, 0 = serving exit; valid while gate_open
cnt_up  output  1  one-cycle increment pulse to the counter
cnt_down  output  1  one-cycle decrement pulse to the counter
full  output  1  count >= MAX_CARS, combinational
empty  output  1  count == 0, combinational
reject  output  1  one-cycle pulse when an entry or exit request is dropped
timeout  output  1  one-cycle pulse when PASS_TIMEOUT expires
state  output  3  current FSM state encoding

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, pending_in=pending_out=0, timer=0, last_served=exit. All registered outputs are 0.
- Request capture: a rising edge of entry_req sets pending_in, and a rising edge of exit_req sets pending_out. Edge detection uses a registered copy of each request, cleared to 0 on reset. An edge on an already-set pending bit has no effect.
- State encodings: IDLE=0, OPEN_IN=1, OPEN_OUT=2, CLOSE=3. Codes 4–7 are illegal and recover to IDLE on the next clock.
- IDLE, grant decision:
  - Only pending_in set: if full, clear pending_in, pulse reject and stay in IDLE. Otherwise clear pending_in and go to OPEN_IN.
  - Only pending_out set: if empty, clear pending_out, pulse reject and stay. Otherwise clear pending_out and go to OPEN_OUT.
  - Both set: the direction opposite to last_served wins. The loser stays pending. A full/empty rejection applies to the winner only, within the same cycle.
  - last_served updates on every grant.
- OPEN_IN / OPEN_OUT:
  - gate_open=1; gate_dir=1 in OPEN_IN and 0 in OPEN_OUT.
  - The timer counts up from 0.
  - On car_passed: pulse cnt_up (OPEN_IN) or cnt_down (OPEN_OUT) in the following cycle (registered), then go to CLOSE.
  - If the timer reaches PASS_TIMEOUT-1 with no car_passed: pulse timeout, go to CLOSE, no count pulse.
  - If car_passed and timer expiry land in the same cycle, car_passed wins.
- CLOSE: gate_open=0; hold CLOSE_HOLD cycles, then go to IDLE. Requests that arrive here are latched and served afterwards.
- car_passed in IDLE or CLOSE is ignored, with no count pulse.
- cnt_up and cnt_down are never asserted in the same cycle. There is at most one count pulse per gate cycle.
- Latency:
  - Request edge to gate_open = 2 cycles (edge register + grant).
  - car_passed to cnt_up/cnt_down = 1 cycle.
- Reset mid-operation: the gate closes immediately and no count pulse is issued.
- Timer width: $clog2(max(PASS_TIMEOUT, CLOSE_HOLD)+1) bits; the timer is cleared on every state entry.

Decomposition:
- Shared package gate_pkg holds:
  - the state encodings (IDLE/OPEN_IN/OPEN_OUT/CLOSE) as localparams;
  - the DIR_IN/DIR_OUT constants;
  - the default MAX_CARS.
- One natural sub-module, req_latch: edge detector plus sticky pending bit with a clear input. It is instantiated twice, once for entry and once for exit.
- The FSM, timer and round-robin logic stay in gate_arbiter.

Test Plan:
- Entry, normal pass: count=5, entry_req rises → gate_open=1, gate_dir=1 two cycles later. Then car_passed → cnt_up pulses 1 cycle later, gate_open=0, state=CLOSE, IDLE after 4 cycles.
- Full garage: count=50, entry_req rises → reject pulse, gate_open stays 0, no cnt_up. Then exit_req rises → OPEN_OUT and cnt_down on pass.
- Simultaneous requests: entry_req and exit_req rise in the same cycle after reset (last_served=exit) → entry served first. Exit is served after CLOSE, with no extra edge needed.
- Timeout: grant entry, no car_passed for 64 cycles → timeout pulses once, no cnt_up, state goes to CLOSE. Also check car_passed in the expiry cycle gives cnt_up and no timeout.
- Empty exit and stray sensor: count=0, exit_req rises → reject. car_passed in IDLE → no cnt_up/cnt_down.
- Async reset mid-open: assert reset=0 while in OPEN_IN → gate_open=0 immediately, state=0, pending cleared, no count pulse after release.
